// File: rtl/alu_mul_seq_if.sv
// Handshake bundle between the execute stage and the sequential multiplier.
// master drives the request (start/op_a/op_b); slave returns ready/valid/product/zero.
interface alu_mul_seq_if #(
  parameter int unsigned WIDTH = 64
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             ready;
  logic             valid;
  logic [WIDTH-1:0] product;
  logic             zero;

  modport master (
    output start, op_a, op_b,
    input  ready, valid, product, zero
  );

  modport slave (
    input  start, op_a, op_b,
    output ready, valid, product, zero
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Sequential shift-and-add multiplier built around one alu instance (low 64 bits of op_a*op_b).
// Optional MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.
module alu #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_control,
  output logic [WIDTH-1:0] result,
  output logic             zero
);
  always_comb begin
    result = '0;
    case (alu_control)
      4'b0000: result = a & b;
      4'b0001: result = a | b;
      4'b0010: result = a + b;
      4'b0110: result = a - b;
      4'b0111: result = b;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);
endmodule

module alu_mul_seq #(
  parameter int unsigned WIDTH = 64
) (
  input logic          clk,
  input logic          reset,
  alu_mul_seq_if.slave bus
);
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [3:0] AluAdd   = 4'b0010;
  localparam logic [3:0] AluPassB = 4'b0111;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [5:0]       count_q, count_d;
  logic [WIDTH-1:0] product_q, product_d;
  logic             zero_q, zero_d;

  logic [3:0]       alu_control;
  logic [WIDTH-1:0] alu_result;
  logic             unused_alu_zero;
  logic [WIDTH-1:0] mplier_shr;
  logic             run_last;

  // Add the shifted multiplicand when the current multiplier bit is set, else keep acc.
  assign alu_control = mplier_q[0] ? AluAdd : AluPassB;

  alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a           (mcand_q),
    .b           (acc_q),
    .alu_control (alu_control),
    .result      (alu_result),
    .zero        (unused_alu_zero)
  );

  assign mplier_shr = mplier_q >> 1;

`ifdef MUL_EARLY_EXIT_EN
  assign run_last = (count_q == 6'd63) || (mplier_shr == '0);
`else
  assign run_last = (count_q == 6'd63);
`endif

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    count_d   = count_q;
    product_d = product_q;
    zero_d    = zero_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          acc_d    = '0;
          mcand_d  = bus.op_a;
          mplier_d = bus.op_b;
          count_d  = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        acc_d    = alu_result;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_shr;
        count_d  = count_q + 6'd1;
        if (run_last) begin
          state_d   = StDone;
          product_d = alu_result;
          zero_d    = (alu_result == '0);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      count_q   <= '0;
      product_q <= '0;
      zero_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      count_q   <= count_d;
      product_q <= product_d;
      zero_q    <= zero_d;
    end
  end

  assign bus.ready   = (state_q == StIdle);
  assign bus.valid   = (state_q == StDone);
  assign bus.product = product_q;
  assign bus.zero    = zero_q;
endmodule

// File: tb/tb_alu_mul_seq.sv
// Randomized self-checking bench for alu_mul_seq against a plain-arithmetic product/latency model.
// Honours MUL_EARLY_EXIT_EN when the same macro is defined for the bench.
module tb_alu_mul_seq;
  localparam int unsigned Width = 64;

  logic clk = 1'b0;
  logic reset;

  alu_mul_seq_if #(.WIDTH(Width)) bus ();

  alu_mul_seq #(
    .WIDTH (Width)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%h, expected 0x%h", tag, obs, exp);
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  // Edges from accept to the edge that raises valid.
  function automatic int exp_latency(input logic [63:0] b);
    int msb_plus1 = 1;
    for (int i = 0; i < 64; i++) if (b[i]) msb_plus1 = i + 1;
`ifdef MUL_EARLY_EXIT_EN
    return msb_plus1;
`else
    return (msb_plus1 > 0) ? 64 : 0;
`endif
  endfunction

  task automatic watch_quiet(input string tag, input int cycles);
    int hits = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (bus.valid) hits++;
    end
    check(tag, 64'(hits), 64'd0);
  endtask

  task automatic do_mul(input logic [63:0] a, input logic [63:0] b, input bit inject);
    logic [63:0] exp_p;
    int          lat;
    int          edges;
    bit          seen;
    exp_p = a * b;
    lat   = exp_latency(b);
    edges = 0;
    seen  = 1'b0;
    bus.start = 1'b1;
    bus.op_a  = a;
    bus.op_b  = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op_a  = rand64();
    bus.op_b  = rand64();
    check("ready_drop", 64'(bus.ready), 64'd0);
    while (!seen && edges < 100) begin
      // New request sampled at RUN edge 10 must be ignored.
      bus.start = inject && (edges == 9);
      @(posedge clk); #1;
      edges++;
      if (bus.valid) seen = 1'b1;
    end
    bus.start = 1'b0;
    check("valid_seen", 64'(seen), 64'd1);
    check("latency", 64'(edges), 64'(lat));
    check("product", bus.product, exp_p);
    check("zero", 64'(bus.zero), 64'(exp_p == 64'd0));
    check("ready_in_done", 64'(bus.ready), 64'd0);
    bus.start = inject;
    bus.op_a  = rand64();
    bus.op_b  = rand64();
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("valid_one_cycle", 64'(bus.valid), 64'd0);
    check("ready_back", 64'(bus.ready), 64'd1);
    check("product_hold", bus.product, exp_p);
    if (inject) watch_quiet("no_extra_valid", 70);
  endtask

  initial begin
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 64'(bus.ready), 64'd1);
    check("rst_valid", 64'(bus.valid), 64'd0);
    check("rst_product", bus.product, 64'd0);
    check("rst_zero", 64'(bus.zero), 64'd1);
    reset = 1'b1;

    do_mul(64'd3, 64'd5, 1'b0);
    do_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0);
    do_mul(64'h8000_0000_0000_0000, 64'd2, 1'b0);
    do_mul(64'h0000_C0CA_C01A_1111, 64'd0, 1'b0);
    do_mul(64'h10, 64'd5, 1'b0);
    do_mul(64'h1234_5678_9ABC_DEF1, 64'h8000_0000_0000_0000, 1'b0);
    do_mul(64'd11, 64'd13, 1'b1);

    // Abort mid-run; no stale completion may follow.
    bus.start = 1'b1;
    bus.op_a  = rand64();
    bus.op_b  = 64'hFFFF_0000_0000_0001;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("abort_ready", 64'(bus.ready), 64'd1);
    check("abort_valid", 64'(bus.valid), 64'd0);
    check("abort_product", bus.product, 64'd0);
    check("abort_zero", 64'(bus.zero), 64'd1);
    watch_quiet("abort_no_valid", 70);
    do_mul(64'd7, 64'd6, 1'b0);

    for (int i = 0; i < 24; i++) begin
      logic [63:0] a;
      logic [63:0] b;
      a = rand64();
      b = rand64() >> $urandom_range(0, 63);
      if (i % 8 == 7) b = '0;
      do_mul(a, b, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Sequential 64-bit multiplier controller for the single-cycle processor datapath. It implements MUL by driving one internal `alu` instance through repeated shift-and-add iterations, using ALUControl 0010 (add) and 0111 (pass b). The product is the low 64 bits, which are identical for signed and unsigned operands. It sits beside the main ALU in the execute stage and reports completion with a ready/start/valid handshake.

## Interface
- `WIDTH`, 64: operand and product width. The only supported value is 64, matching `alu`.
- `clk` input 1: clock, rising edge active.
- `reset` input 1: synchronous, active-low reset, sampled on rising `clk`.
- `start` input 1: request a multiply. Sampled only when `ready`=1.
- `op_a` input 64: multiplicand, captured on the accepting edge.
- `op_b` input 64: multiplier, captured on the accepting edge.
- `ready` output 1: high in IDLE; the block can accept `start`.
- `valid` output 1: one-cycle pulse; `product` and `zero` are valid.
- `product` output 64: low 64 bits of `op_a*op_b`, held until the next accept.
- `zero` output 1: high when `product`==0, held with `product`.

## Operation
- Registers:
  - `acc` (64)
  - `mcand` (64)
  - `mplier` (64)
  - `count` (6)
  - `state` ∈ {IDLE, RUN, DONE}
- ALU hookup: a=`mcand`, b=`acc`. ALUControl is 0010 when `mplier[0]`=1, otherwise 0111 (pass `acc`).
- IDLE: when `start`=1, the edge loads `acc`=0, `mcand`=`op_a`, `mplier`=`op_b`, `count`=0, and moves to RUN. When `start`=0, the block stays in IDLE.
- RUN, on each edge:
  - `acc` ← ALU result
  - `mcand` ← `mcand`<<1, MSB dropped
  - `mplier` ← `mplier`>>1, zero filled
  - `count` ← `count`+1
- RUN exit: moves to DONE on the edge where `count`==63 (64th iteration).
- DONE: `valid`=1; `product`←`acc` and `zero`←(`acc`==0) are registered on entry to DONE. The next edge returns to IDLE.
- Overflow: product bits above 63 are discarded silently. The ALU `zero` output is unused.
- `start` while `ready`=0 (RUN or DONE) is ignored. The request is not queued.
- `op_a` and `op_b` are don't-care outside the accepting edge.

## Timing
- Reset (`reset`=0 at an edge) forces state IDLE and sets `ready`=1, `valid`=0, `product`=0, `zero`=1, `acc`/`mcand`/`mplier`/`count`=0.
- Reset mid-operation aborts immediately. The next cycle starts in IDLE with no `valid` pulse.
- Latency: with E0 the edge that samples `start`=1, iterations occur at E1..E64. `valid` is high during the cycle following E64 and deasserts at E65.
- `ready` drops the cycle after E0 and returns the cycle after the DONE edge. Minimum accept-to-accept spacing is 66 edges.
- `product` and `zero` update only on entry to DONE. They are stable from that point until the next completion or reset.
- `valid` is never high for more than one consecutive cycle.

## Configuration
- `MUL_EARLY_EXIT_EN` defined: RUN also exits to DONE on any edge where the updated `mplier` (after the shift) is 0.
  - Latency = index of the highest set bit of `op_b` + 1 edges.
  - `op_b`=0 gives 1 edge (one RUN cycle).
  - The product is unchanged.
- `MUL_EARLY_EXIT_EN` undefined: fixed 64-iteration latency for every operand. `mplier` is not tested for zero.

## Test plan
- Basic product, `op_a`=3, `op_b`=5, macro off: `valid` pulses once, 64 edges after the accept edge, with `product`=0xF and `zero`=0.
- Wrap-around, `op_a`=0xFFFF_FFFF_FFFF_FFFF, `op_b`=2: `product`=0xFFFF_FFFF_FFFF_FFFE. Also `op_a`=0x8000_0000_0000_0000, `op_b`=2: `product`=0, `zero`=1.
- Zero operand, `op_a`=0x0000_C0CA_C01A_1111, `op_b`=0: `product`=0, `zero`=1. With `MUL_EARLY_EXIT_EN`, `valid` arrives 1 edge after accept.
- Ignored start: pulse `start` with new operands at RUN edge 10 and again during DONE. There is exactly one `valid`, for the original operands. `ready` returns the cycle after DONE.
- Reset mid-operation: drive `reset`=0 at RUN edge 30. The next cycle shows `ready`=1, `valid`=0, `product`=0, `zero`=1, and no stale `valid` follows. A fresh 7×6 then yields 0x2A.
- Early exit (macro defined), `op_b`=5, `op_a`=0x10: `valid` arrives 3 edges after accept with `product`=0x50. `op_b`=0x8000_0000_0000_0000 still takes 64 edges.
